huffman_stream_ctrl: RTL
========================

// Module: huffman_stream_ctrl
// PURPOSE
//  Sequences huffman_decoder: accepts a byte stream over valid/ready and feeds it MSB-first, one bit per strobe.
//  Collects the decoder's 3-bit symbols and drops NULL (0) outputs.
//  Delivers symbols through a small FIFO with valid/ready and marks the end of each stream.
//  Detects streams that end mid-codeword, then returns the decoder to its root state.
// PARAMETERS
//  SYM_DEPTH  4  symbol FIFO entries; power of 2, >=2
//  CNT_W     16  width of sym_count
// PORTS
//  clk        in   1      single clock, rising edge
//  reset      in   1      asynchronous, active-high
//  in_data    in   8      stream byte; bit 7 is decoded first
//  in_valid   in   1      in_data/in_last/in_nbits valid
//  in_last    in   1      final byte of stream
//  in_nbits   in   4      valid bits in last byte, MSB-aligned; 1..8; 0 or >8 => 8; ignored if !in_last
//  in_ready   out  1      byte accepted when in_valid & in_ready
//  dec_x      out  1      bit to decoder
//  dec_en     out  1      decoder advance strobe; decoder consumes dec_x only when 1
//  dec_rst    out  1      to decoder reset; = reset | internal one-cycle clear pulse
//  dec_y      in   3      decoder output; registered; valid the cycle after dec_en
//  sym_data   out  3      decoded symbol, 1..6 (A..F)
//  sym_valid  out  1      FIFO not empty
//  sym_ready  in   1      symbol popped when sym_valid & sym_ready
//  sym_last   out  1      with sym_data: last symbol of a cleanly ended stream
//  err_trunc  out  1      stream ended mid-codeword; level
//  busy       out  1      state != IDLE
//  sym_count  out  CNT_W  symbols pushed since reset; wraps
// BEHAVIOUR
//  Reset values:
//   - all outputs 0 except dec_rst=1 while reset is high
//   - FIFO empty; state IDLE
//  States:
//   - IDLE: in_ready=1. On accept, load shift reg and bit counter (8, or in_nbits if last), latch last flag; go SHIFT.
//   - SHIFT: issue one bit when (fifo_count + pending) < SYM_DEPTH.
//     Issue = dec_en=1, dec_x=shreg[7]; shift left; decrement bit counter; set pending.
//   - WAIT (1 cycle after final bit of byte): sample dec_y.
//     Not last byte: go IDLE.
//     Last byte: go CHECK.
//   - CHECK: if final response was NULL, set err_trunc, pulse dec_rst 1 cycle, go IDLE. Else go IDLE.
//  Response handling:
//   - The cycle after any issue: if dec_y!=0, push dec_y into the FIFO and increment sym_count.
//   - The tag is set when the pushed bit is the final bit of a last byte.
//   - mid_cw <= (dec_y==0) tracks an open codeword.
//  Pipelining:
//   - A byte is accepted in IDLE only, so there is >=1 bubble cycle between bytes.
//   - Decoder state persists across bytes; codewords may span bytes.
//  Throughput: one bit per cycle within a byte when the FIFO has space.
//  Backpressure: the FIFO never overflows; the issue gate counts the in-flight bit. With sym_ready=0, issuing stops at SYM_DEPTH.
//  Simultaneous push and pop: both occur; count unchanged.
//  err_trunc: cleared when the next byte is accepted. No symbol is emitted for a truncated codeword. No sym_last is produced for that stream.
//  Async reset mid-operation:
//   - FIFO and pending bits discarded; decoder reset via dec_rst
//   - next byte decodes from root
// TESTING
//  1) 0x58, nbits=8, last -> symbols 1,2,3,1 (A,B,C,A); sym_last only on the 4th; err_trunc=0; sym_count=4.
//  2) 0x06 not last, then 0x80 nbits=1 last -> A x5 then E(5) with sym_last. Codeword spans the byte boundary.
//  3) 0x80 nbits=2 last -> no symbols; err_trunc=1; dec_rst high exactly 1 cycle.
//     Then 0x00 nbits=1 last -> A with sym_last; err_trunc=0.
//  4) sym_ready=0, 0x00 nbits=8 last -> exactly SYM_DEPTH A's queued; dec_en stays 0.
//     Release sym_ready -> the 8 A's arrive in order; sym_last on the 8th.
//  5) reset asserted after 3 bits of 0xE0 -> all outputs 0, FIFO empty.
//     Then 0xF0 nbits=3 last -> D(4) with sym_last.
//  6) sym_ready toggled every cycle during 2 full bytes of 0x00 -> 16 A's; no loss or duplication; sym_count=16.

Source files
------------

// File: rtl/huffman_stream_ctrl.sv
// ---------------------------------------------------------------------------
// huffman_stream_ctrl
//   Sequences an external huffman_decoder. Bytes arrive over a valid/ready
//   handshake and are fed to the decoder MSB-first, one bit per dec_en strobe.
//   Non-NULL decoder responses are queued in a small symbol FIFO. The final
//   symbol of a cleanly ended stream is tagged with sym_last. A stream that
//   ends inside a codeword raises err_trunc and gets a one-cycle decoder clear.
//
// Ports
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   in_data/in_valid    stream byte (bit 7 first) and its valid
//   in_last/in_nbits    final byte flag; valid MSB-aligned bits in final byte
//   in_ready            byte accepted when in_valid & in_ready
//   dec_x/dec_en        bit and advance strobe to the decoder
//   dec_rst             decoder reset (reset or internal clear pulse)
//   dec_y               registered decoder response, valid cycle after dec_en
//   sym_data/sym_valid  FIFO head symbol (1..6) and not-empty flag
//   sym_ready           pops the head symbol
//   sym_last            head symbol closes a cleanly ended stream
//   err_trunc           last stream ended mid-codeword (cleared on next byte)
//   busy                controller not idle
//   sym_count           symbols pushed since reset, wrapping
// ---------------------------------------------------------------------------
module huffman_stream_ctrl #(
  parameter int unsigned SYM_DEPTH = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  input  logic             in_last,
  input  logic [3:0]       in_nbits,
  output logic             in_ready,
  output logic             dec_x,
  output logic             dec_en,
  output logic             dec_rst,
  input  logic [2:0]       dec_y,
  output logic [2:0]       sym_data,
  output logic             sym_valid,
  input  logic             sym_ready,
  output logic             sym_last,
  output logic             err_trunc,
  output logic             busy,
  output logic [CNT_W-1:0] sym_count
);

  localparam int unsigned PW = (SYM_DEPTH > 1) ? $clog2(SYM_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] DEPTH_L = SYM_DEPTH[CW:0];

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_CHECK = 2'd3;

  logic [1:0]       state;
  logic [7:0]       shreg;
  logic [3:0]       bitcnt;
  logic             last_flag;
  logic             pending;   // a bit was issued last cycle; dec_y is its response
  logic             pend_tag;  // that bit was the final bit of a last byte
  logic             mid_cw;    // decoder holds an open codeword
  logic             err_q;
  logic             clr_q;     // one-cycle decoder clear after a truncated stream
  logic             alive;     // holds in_ready low until the first cycle after reset

  logic [3:0]       fifo_mem [SYM_DEPTH];  // {tag, symbol}
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    fifo_cnt;
  logic [CNT_W-1:0] cnt_q;

  logic             accept;
  logic             issue;
  logic             push;
  logic             pop;
  logic [3:0]       nbits_eff;
  logic [CW:0]      inflight;

  always_comb begin
    nbits_eff = in_nbits;
    if (in_nbits == 4'd0 || in_nbits > 4'd8) begin
      nbits_eff = 4'd8;
    end
  end

  // The gate counts the bit whose response has not yet reached the FIFO,
  // so a full FIFO can never be overrun by a late response.
  always_comb begin
    inflight = {1'b0, fifo_cnt} + {{CW{1'b0}}, pending};
    issue    = (state == ST_SHIFT) && (inflight < DEPTH_L);
  end

  assign in_ready  = alive && (state == ST_IDLE);
  assign accept    = in_valid && in_ready;
  assign push      = pending && (dec_y != 3'd0);
  assign sym_valid = (fifo_cnt != '0);
  assign pop       = sym_valid && sym_ready;

  assign dec_en    = issue;
  assign dec_x     = issue && shreg[7];
  assign dec_rst   = reset | clr_q;
  assign sym_data  = sym_valid ? fifo_mem[rd_ptr][2:0] : 3'd0;
  assign sym_last  = sym_valid && fifo_mem[rd_ptr][3];
  assign err_trunc = err_q;
  assign busy      = (state != ST_IDLE);
  assign sym_count = cnt_q;

  // Sequencing FSM and response tracking
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      bitcnt    <= '0;
      last_flag <= 1'b0;
      pending   <= 1'b0;
      pend_tag  <= 1'b0;
      mid_cw    <= 1'b0;
      err_q     <= 1'b0;
      clr_q     <= 1'b0;
      alive     <= 1'b0;
    end else begin
      alive   <= 1'b1;
      clr_q   <= 1'b0;
      pending <= issue;
      if (issue) begin
        pend_tag <= last_flag && (bitcnt == 4'd1);
      end
      if (pending) begin
        mid_cw <= (dec_y == 3'd0);
      end

      case (state)
        ST_IDLE: begin
          if (accept) begin
            shreg     <= in_data;
            bitcnt    <= in_last ? nbits_eff : 4'd8;
            last_flag <= in_last;
            err_q     <= 1'b0;
            state     <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (issue) begin
            shreg  <= {shreg[6:0], 1'b0};
            bitcnt <= bitcnt - 4'd1;
            if (bitcnt == 4'd1) begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          // The final response is absorbed into mid_cw this cycle.
          state <= last_flag ? ST_CHECK : ST_IDLE;
        end
        default: begin
          if (mid_cw) begin
            err_q  <= 1'b1;
            clr_q  <= 1'b1;
            mid_cw <= 1'b0;
          end
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Symbol FIFO pointers and counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        cnt_q  <= cnt_q + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Storage is unreset; outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {pend_tag, dec_y};
    end
  end

endmodule
